lfsr_rand_arbiter: RTL
======================

// Module: lfsr_rand_arbiter
// PURPOSE
//  Shares one Galois LFSR random source among NREQ requesters (sound channels, sprite jitter, AI).
//  A round-robin arbiter picks one requester, advances the LFSR STEPS times, then returns the
//  value with a one-cycle grant. Sits between game-logic requesters and the shared noise source.
// PARAMETERS
//  NREQ     4         number of requesters (2..8)
//  NBITS    8         LFSR width
//  TAPS     8'h1D     Galois tap mask, XORed in when the shifted-out MSB is 1
//  SEED     8'h01     reset value of LFSR (0 is coerced to 1)
//  STEPS    1         LFSR advances per grant (1..15)
//  FREE_RUN 1         1: LFSR also advances every cycle while IDLE
// PORTS
//  clk        in   1       system clock
//  reset      in   1       asynchronous, active-low (asserted at 0)
//  req        in   NREQ    level request per requester; held until its gnt bit pulses
//  gnt        out  NREQ    one-hot grant, high exactly one cycle
//  rnd_data   out  NBITS   random value, valid while rnd_valid=1
//  rnd_valid  out  1       high same cycle as gnt (gnt != 0)
//  seed_load  in   1       load seed_val into LFSR
//  seed_val   in   NBITS   seed value
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  - Reset (reset=0, async): lfsr=SEED (or 1 if SEED=0), state=IDLE, ptr=0, cnt=0, gnt=0,
//    rnd_data=0, rnd_valid=0.
//  - Step function: next = {lfsr[NBITS-2:0],1'b0} ^ (lfsr[NBITS-1] ? TAPS : 0); if lfsr==0, next=1.
//  - FSM IDLE/STEP/GRANT, registered outputs:
//    IDLE: LFSR steps each cycle iff FREE_RUN. If |req: winner=first set bit scanning from ptr
//      upward with wrap; latch winner; cnt<=0; ->STEP.
//    STEP: LFSR steps each cycle; cnt++. On cnt==STEPS-1: rnd_data<=next, gnt<=onehot(winner),
//      rnd_valid<=1, ->GRANT.
//    GRANT: gnt/rnd_valid high this cycle only; ptr<=(winner+1) mod NREQ; ->IDLE (next req can be
//      sampled the following cycle). LFSR holds in GRANT.
//  - Latency: req sampled at edge E -> gnt/rnd_valid high in cycle after edge E+STEPS, for 1 cycle.
//    Minimum grant spacing is STEPS+2 cycles.
//  - Winner dropping req during STEP: grant still issued (protocol violation, no abort).
//  - seed_load: highest priority, any state: lfsr<=seed_val (0 coerced to 1); in-flight request
//    aborted (->IDLE, gnt/rnd_valid=0, ptr unchanged); req ignored that cycle.
//  - Asserting reset mid-STEP/GRANT: immediate return to reset values; no grant issued.
//  - Arithmetic: cnt is 4 bits; ptr is $clog2(NREQ) bits, wraps at NREQ (not a power of 2).
// STRUCTURE
//  - Shared header (lfsr_defs.vh, include-guarded): state encodings ST_IDLE=0, ST_STEP=1,
//    ST_GRANT=2 and the LFSR step function macro, reused by other LFSR consumers.
//  - Sub-module rr_pick (combinational): inputs req, ptr; outputs winner index + any.
//  - Top: FSM, LFSR register, step counter, output registers.
// TESTING (NBITS=8, TAPS=8'h1D, SEED=8'h01, STEPS=1, FREE_RUN=0, NREQ=4 unless noted)
//  1 Reset then req=4'b0001 at edge 0 -> gnt=4'b0001, rnd_data=8'h02, rnd_valid=1 after edge 1, 1 cycle.
//  2 req=4'b1111 held -> gnt sequence 0001,0010,0100,1000,0001, each 3 cycles apart.
//  3 seed_load, seed_val=8'h80; then req=4'b0100 -> gnt=4'b0100, rnd_data=8'h1D.
//  4 seed_load, seed_val=8'h00 -> lfsr=8'h01; next grant rnd_data=8'h02 (no lockup).
//  5 STEPS=3: seed 8'h01, req=4'b0010 -> rnd_data=8'h08, gnt high 4 cycles after req sampled.
//  6 reset=0 during STEP (and seed_load during STEP) -> no gnt; busy=0 next cycle; ptr unchanged.

Source files
------------

// File: rtl/lfsr_rand_arbiter_pkg.sv
// Shared definitions for the LFSR random-source arbiter: FSM encoding and counter width.
package lfsr_rand_arbiter_pkg;

    // Encodings are fixed so other LFSR consumers can decode the state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_GRANT = 2'd2
    } arb_state_e;

    localparam int CNT_W = 4;

endpackage

// File: rtl/lfsr_rand_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping at NREQ.
module lfsr_rand_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [PW-1:0]   winner_o,
    output logic            any_o
);

    // Scan from the farthest offset down so the closest match to ptr is the last one kept.
    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr_i) + k) % NREQ;
            if (req_i[idx]) begin
                winner_o = PW'(idx);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lfsr_rand_arbiter.sv
// Round-robin arbiter sharing one Galois LFSR; each grant advances the LFSR STEPS times.
module lfsr_rand_arbiter
    import lfsr_rand_arbiter_pkg::*;
#(
    parameter int               NREQ     = 4,
    parameter int               NBITS    = 8,
    parameter logic [NBITS-1:0] TAPS     = 8'h1D,
    parameter logic [NBITS-1:0] SEED     = 8'h01,
    parameter int               STEPS    = 1,
    parameter int               FREE_RUN = 1
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [NREQ-1:0]  req_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [NBITS-1:0] rnd_data_o,
    output logic             rnd_valid_o,
    input  logic             seed_load_i,
    input  logic [NBITS-1:0] seed_val_i,
    output logic             busy_o
);

    localparam int               PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NBITS-1:0] SEED_C = (SEED == '0) ? NBITS'(1) : SEED;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(STEPS - 1);

    // One Galois shift; the all-zero lockup state is forced back to 1.
    function automatic logic [NBITS-1:0] lfsr_step(input logic [NBITS-1:0] v);
        logic [NBITS-1:0] n;
        n = {v[NBITS-2:0], 1'b0} ^ (v[NBITS-1] ? TAPS : '0);
        if (v == '0) n = NBITS'(1);
        return n;
    endfunction

    arb_state_e       state_q, state_d;
    logic [NBITS-1:0] lfsr_q, lfsr_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NBITS-1:0] rnd_q, rnd_d;
    logic             vld_q, vld_d;

    logic [PW-1:0]    pick_win;
    logic             pick_any;
    logic [NBITS-1:0] lfsr_nxt;

    assign lfsr_nxt = lfsr_step(lfsr_q);

    lfsr_rand_arbiter_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .winner_o (pick_win),
        .any_o    (pick_any)
    );

    // Next-state logic: seed load overrides everything and aborts any in-flight request.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        rnd_d   = rnd_q;
        gnt_d   = '0;
        vld_d   = 1'b0;
        if (seed_load_i) begin
            lfsr_d  = (seed_val_i == '0) ? NBITS'(1) : seed_val_i;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (FREE_RUN != 0) lfsr_d = lfsr_nxt;
                    if (pick_any) begin
                        win_d   = pick_win;
                        cnt_d   = '0;
                        state_d = ST_STEP;
                    end
                end
                ST_STEP: begin
                    lfsr_d = lfsr_nxt;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        rnd_d   = lfsr_nxt;
                        gnt_d   = NREQ'(1) << win_q;
                        vld_d   = 1'b1;
                        state_d = ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // ptr wraps at NREQ, which need not be a power of two.
                    ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : PW'(win_q + 1'b1);
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, LFSR and registered outputs.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED_C;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            rnd_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            rnd_q   <= rnd_d;
            vld_q   <= vld_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign rnd_data_o  = rnd_q;
    assign rnd_valid_o = vld_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
